// File: rtl/psg_i2s_tx.sv
// PSG audio output stage: box-averages the PSG level over one I2S frame and
// serialises it as a 16-bit two's-complement I2S stereo stream (same word on both channels).
module psg_i2s_tx #(
    parameter int unsigned DIV_LOG2 = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] aIn,
    input  logic        mute,
    output logic        bclk,
    output logic        lrclk,
    output logic        sdata,
    output logic [15:0] sample,
    output logic        sampleStrobe
);

    localparam int unsigned CntW = 7 + DIV_LOG2;
    localparam int unsigned AccW = 23 + DIV_LOG2;
    localparam logic [CntW-1:0] CntLast = '1;

    logic [CntW-1:0] cntQ, cntD;
    logic [AccW-1:0] accQ, accD, accSum;
    logic [15:0]     sampleQ, sampleD;
    logic            strobeQ, strobeD;
    logic            bclkQ, bclkD;
    logic            lrclkQ, lrclkD;
    logic            sdataQ, sdataD;
    logic            frameEnd;
    logic [5:0]      slot;
    logic [4:0]      slotLow;
    logic [3:0]      bitIdx;

    // Averaging: the sum includes this cycle's aIn so the word covers exactly F samples.
    always_comb begin
        frameEnd = (cntQ == CntLast);
        cntD     = cntQ + 1'b1;
        accSum   = accQ + AccW'(aIn);
        accD     = frameEnd ? '0 : accSum;
        sampleD  = sampleQ;
        strobeD  = 1'b0;
        if (frameEnd) begin
            sampleD = mute ? 16'h0000 : (accSum[AccW-1:CntW] ^ 16'h8000);
            strobeD = 1'b1;
        end
    end

    // Serial outputs follow the next count; slot 0 after a wrap is always idle,
    // so the current sample register is safe to use for every data slot.
    always_comb begin
        slot    = cntD[CntW-1:DIV_LOG2+1];
        slotLow = slot[4:0];
        bitIdx  = 4'(5'd16 - slotLow);
        bclkD   = cntD[DIV_LOG2];
        lrclkD  = slot[5];
        sdataD  = 1'b0;
        if (slotLow >= 5'd1 && slotLow <= 5'd16) begin
            sdataD = sampleQ[bitIdx];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cntQ    <= '0;
            accQ    <= '0;
            sampleQ <= 16'h0000;
            strobeQ <= 1'b0;
            bclkQ   <= 1'b0;
            lrclkQ  <= 1'b0;
            sdataQ  <= 1'b0;
        end else begin
            cntQ    <= cntD;
            accQ    <= accD;
            sampleQ <= sampleD;
            strobeQ <= strobeD;
            bclkQ   <= bclkD;
            lrclkQ  <= lrclkD;
            sdataQ  <= sdataD;
        end
    end

    assign bclk         = bclkQ;
    assign lrclk        = lrclkQ;
    assign sdata        = sdataQ;
    assign sample       = sampleQ;
    assign sampleStrobe = strobeQ;

endmodule

// File: doc/psg_i2s_tx.md
# psg_i2s_tx

PSG audio output stage. Consumes the 16-bit unsigned mixed PSG level (`aOut` of the PSG top) on every `clock` cycle. Box-averages it over one I2S frame (decimation plus crude low-pass), converts it to two's complement, and serialises the result as a 16-bit I2S stereo stream with the same word on both channels. It sits between the PSG and the board's external audio DAC/codec. `bclk`, `lrclk` and `sdata` are generated from `clock`; there is no other clock domain.

## Interface
- `DIV_LOG2`, default 0: BCLK half-period is 2^DIV_LOG2 `clock` cycles.
  - Frame length F = 2^(7+DIV_LOG2) cycles (64 BCLK).
  - At 3579545 Hz and DIV_LOG2=0, fs = 27965 Hz.
- `clock`  in  1  system clock (PSG clock).
- `reset`  in  1  synchronous, active-high; clock `clock`.
- `aIn`  in  16  unsigned PSG level. Sampled every cycle; 0x8000 = silence midpoint.
- `mute`  in  1  when high at a frame boundary, the latched word is 0x0000.
- `bclk`  out  1  I2S bit clock (registered).
- `lrclk`  out  1  I2S word select; 0 = left, 1 = right (registered).
- `sdata`  out  1  I2S serial data, MSB first (registered).
- `sample`  out  16  word currently being transmitted, two's complement.
- `sampleStrobe`  out  1  one-cycle pulse when `sample` is updated.

## Operation
- **Frame counter `cnt`:** 7+DIV_LOG2 bits, free-running 0..F-1, wraps to 0.
  - Slot index s = cnt >> (DIV_LOG2+1), range 0..63.
  - Phase within slot = low DIV_LOG2+1 bits of `cnt`.
- **Accumulator `acc`:** 23+DIV_LOG2 bits, no overflow possible.
  - Every cycle: acc <= acc + aIn.
  - On the cycle where cnt = F-1: word = (acc + aIn) >> (7+DIV_LOG2), which is the floor of the mean of exactly F samples.
  - On that same cycle: `sample` <= mute ? 0x0000 : word ^ 0x8000; acc <= 0; `sampleStrobe` <= 1.
  - `sampleStrobe` is 0 on all other cycles.
- **Serialiser:** `bclk`, `lrclk`, `sdata` are registers that take the value implied by the new `cnt` on the same edge that updates `cnt`.
  - `bclk` = 0 for the first half of each slot, 1 for the second half.
  - `lrclk` = 0 for s in 0..31, 1 for s in 32..63.
  - `sdata` in slot s:
    - s in 1..16: sample[16-s].
    - s in 33..48: sample[48-s].
    - All other slots: 0.
  - Standard I2S: MSB one BCLK after the LRCLK edge; data and LRCLK change on the falling BCLK; the receiver samples on the rising BCLK.
  - The word used for the whole frame is the `sample` value loaded at the wrap into that frame. `sample` never changes mid-frame.
- **`mute`:** examined only at the frame boundary. Mid-frame changes take effect on the next frame.

## Timing
- **Reset (synchronous):**
  - cnt=0, acc=0, sample=0x0000, sampleStrobe=0, bclk=0, lrclk=0, sdata=0.
  - The first frame after reset transmits 0x0000.
  - The first averaged word contains aIn from the first post-reset cycle through cnt=F-1 (exactly F samples).
- **Reset mid-frame:** the frame is abandoned and the partial accumulation is discarded. Outputs are at reset values on the cycle after `reset` is sampled high. `reset` held high holds all state.
- **Latency:**
  - `aIn` at the cycle cnt=F-1 contributes to the `sample` visible on the next cycle.
  - The MSB of that sample drives `sdata` from cnt=2^(DIV_LOG2+1), i.e. slot 1, until the end of slot 1.
- **Periods:** `sampleStrobe` period is exactly F cycles. The `bclk` period is exactly 2^(DIV_LOG2+1) cycles with 50% duty.
- **Boundary cases:**
  - With aIn=0xFFFF for all F cycles, the mean is 0xFFFF, so sample=0x7FFF. No wrap.
  - With aIn=0x0000, sample=0x8000.
  - `mute` and the boundary in the same cycle: mute wins.

## Test plan
1. DIV_LOG2=0, reset, then aIn=0x8000 constant: sample=0x0000 on every strobe; strobes 128 cycles apart; sdata stays 0.
2. aIn=0xFFFF constant: second strobe gives sample=0x7FFF. Left slots 1..16 and right slots 33..48 read 0111111111111111. lrclk toggles every 64 cycles; bclk period is 2 cycles.
3. aIn alternating 0x0000/0xFFFF every cycle: sample=0xFFFF (mean 32767, floor, then MSB flip). Repeat with DIV_LOG2=2: same value, strobe period 512.
4. Force a frame average of 0x25C3 (sample 0xA5C3): capture sdata on rising bclk; both channels decode 0xA5C3 MSB-first; slots 0 and 17..31 are 0.
5. aIn=0xFFFF with mute raised mid-frame: that frame's word is still 0x7FFF if mute drops before the boundary. If mute is high at the boundary, sample=0x0000 and sdata is all 0 for that frame.
6. Assert reset at cnt=70 for 1 cycle: on the next cycle bclk=lrclk=sdata=0 and sample=0; the next strobe occurs exactly 128 cycles after reset release.
